if_stage: RTL and testbench

Instruction-fetch stage of the zerocpu RV64 core. It sits directly upstream of the decode stage. It owns the fetch PC, issues in-order word requests to the instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake and supports a single-cycle redirect that flushes buffered and in-flight fetches.

---
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word requests
// and buffers returned instructions with their PCs for decode.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q,  discard_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] head_q,     head_d;
    logic [PW-1:0] tail_q,     tail_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [63:0]   pc_mem_q   [DEPTH];

    logic [CW:0]   used;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [63:0]   target;

    // Credit covers FIFO occupancy plus everything in flight, so pushes never overflow.
    assign used           = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = !reset && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push   = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign target = {redirect_pc[63:2], 2'b00};

    assign inst_valid = (count_q != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst       = (count_q != '0) ? inst_mem_q[head_q] : '0;
    assign inst_pc    = (count_q != '0) ? pc_mem_q[head_q]   : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_d  = discard_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            // Every response still outstanding after this cycle belongs to the old path.
            discard_d  = inflight_q - CW'(imem_rsp_valid);
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 64'd4;
                tail_d   = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                inst_mem_q[tail_q] <= imem_rsp_data;
                pc_mem_q[tail_q]   <= rsp_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order memory model with variable latency and
// a reference that expects contiguous PC streams restarting at each redirect target.
module tb_if_stage;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rdy_rand = 1'b0;
    logic [63:0] exp_req;
    logic [63:0] exp_pc;
    int          fires;
    int          xfers;
    int          last_fire_cyc;
    int          last_xfer_cyc;
    logic [63:0] last_fire_addr;
    logic [63:0] last_xfer_pc;
    bit          saw_zero_fire;
    bit          saw_zero_xfer;
    int          tests = 0;
    int          fails = 0;

    // One clock cycle: drive inputs at the falling edge, sample after settling, update model.
    task automatic step(input bit rst, input bit redir, input logic [63:0] tgt, input bit irdy);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = tgt;
        inst_ready     = irdy;
        imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr[31:0];
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (rst) begin
            mq.delete();
            exp_req = RESET_PC;
            exp_pc  = RESET_PC;
        end else begin
            if (redir) begin
                tests++;
                if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL redirect_blocks: req_valid=%b inst_valid=%b, required 0/0",
                             imem_req_valid, inst_valid);
                end
            end
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                tests++;
                if (imem_req_addr !== exp_req) begin
                    fails++;
                    $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_req);
                end
                mq.push_back('{imem_req_addr, cyc + $urandom_range(lat_min, lat_max)});
                if (imem_req_addr == 64'd0) saw_zero_fire = 1'b1;
                last_fire_addr = imem_req_addr;
                last_fire_cyc  = cyc;
                exp_req        = exp_req + 64'd4;
                fires++;
            end
            if (inst_valid === 1'b1 && irdy) begin
                tests++;
                if (inst_pc !== exp_pc || inst !== exp_pc[31:0]) begin
                    fails++;
                    $display("FAIL decode_stream: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc, inst, exp_pc, exp_pc[31:0]);
                end
                if (inst_pc == 64'd0) saw_zero_xfer = 1'b1;
                last_xfer_pc  = inst_pc;
                last_xfer_cyc = cyc;
                exp_pc        = exp_pc + 64'd4;
                xfers++;
            end
            if (redir) begin
                exp_req = {tgt[63:2], 2'b00};
                exp_pc  = {tgt[63:2], 2'b00};
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 ||
            inst_pc !== 64'd0 || imem_req_addr !== RESET_PC) begin
            fails++;
            $display("FAIL %s: req_valid=%b inst_valid=%b inst=%h inst_pc=%h addr=%h, required 0 0 0 0 %h",
                     tag, imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic check_first_request(input string tag);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            fails++;
            $display("FAIL %s: req_valid=%b addr=%h, required 1 %h",
                     tag, imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; rdy_rand = 1'b0;
        do_reset(3);
        check_reset_outputs("reset_values");
        check_first_request("first_request");
    endtask

    task automatic test_stream();
        xfers = 0; fires = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, 1'b1);
        tests++;
        if (xfers < 20 || fires < 20) begin
            fails++;
            $display("FAIL stream_rate: got %0d transfers %0d requests in 40 cycles, required >= 20 each",
                     xfers, fires);
        end
    endtask

    task automatic test_backpressure();
        int fire_c;
        int xfer_c;
        lat_min = 1; lat_max = 1; rdy_rand = 1'b0;
        do_reset(2);
        fires = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);
        tests++;
        if (fires != 2 || imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: got %0d requests, req_valid=%b, required 2 requests and 0",
                     fires, imem_req_valid);
        end
        fires = 0; xfers = 0; fire_c = -1; xfer_c = -1;
        for (int i = 0; i < 10 && fires == 0; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (xfers > 0 && xfer_c < 0) xfer_c = last_xfer_cyc;
        end
        if (fires > 0) fire_c = last_fire_cyc;
        tests++;
        if (fire_c < 0 || xfer_c < 0 || fire_c != xfer_c + 1 || last_fire_addr !== 64'h8000_0008) begin
            fails++;
            $display("FAIL bp_release: fire cycle %0d addr %h, first pop cycle %0d, required pop+1 and 80000008",
                     fire_c, last_fire_addr, xfer_c);
        end
    endtask

    task automatic test_redirect_inflight();
        bit ok;
        lat_min = 3; lat_max = 3; rdy_rand = 1'b0;
        do_reset(2);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (mq.size() == 2) ok = 1'b1;
            else step(1'b0, 1'b0, '0, 1'b1);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL inflight_setup: got %0d in flight, required 2", mq.size());
        end
        step(1'b0, 1'b1, 64'h8000_0102, 1'b1);
        fires = 0; xfers = 0;
        for (int i = 0; i < 20 && xfers == 0; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (fires == 1 && xfers == 0) begin
                tests++;
                if (last_fire_addr !== 64'h8000_0100) begin
                    fails++;
                    $display("FAIL redirect_req: got %h, required 80000100", last_fire_addr);
                end
            end
        end
        tests++;
        if (xfers == 0 || last_xfer_pc !== 64'h8000_0100) begin
            fails++;
            $display("FAIL redirect_first_pc: got %0d transfers pc=%h, required pc 80000100",
                     xfers, last_xfer_pc);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_redirect_coincident();
        bit hit;
        lat_min = 3; lat_max = 3; rdy_rand = 1'b0;
        do_reset(2);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (inst_valid === 1'b1 && mq.size() > 0 && mq[0].due <= cyc) begin
                step(1'b0, 1'b1, 64'h8000_0200, 1'b1);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, '0, 1'b1);
            end
        end
        redirect_valid = 1'b0;
        #1;
        tests++;
        if (!hit || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0) begin
            fails++;
            $display("FAIL coincident_flush: hit=%b inst_valid=%b inst=%h pc=%h, required 1 0 0 0",
                     hit, inst_valid, inst, inst_pc);
        end
        xfers = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1);
        tests++;
        if (xfers < 3) begin
            fails++;
            $display("FAIL coincident_resume: got %0d transfers, required >= 3", xfers);
        end
    endtask

    task automatic test_wrap_back_to_back();
        lat_min = 1; lat_max = 3; rdy_rand = 1'b1;
        saw_zero_fire = 1'b0; saw_zero_xfer = 1'b0;
        step(1'b0, 1'b1, 64'h0000_1234_0000_0040, 1'b1);
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        xfers = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, 1'b1);
        tests++;
        if (!saw_zero_fire || !saw_zero_xfer || xfers < 3) begin
            fails++;
            $display("FAIL wrap: zero request=%b zero pc=%b transfers=%0d, required 1 1 >=3",
                     saw_zero_fire, saw_zero_xfer, xfers);
        end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        lat_min = 3; lat_max = 3; rdy_rand = 1'b0;
        do_reset(2);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (inst_valid === 1'b1 && mq.size() > 0) ok = 1'b1;
            else step(1'b0, 1'b0, '0, 1'b0);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midstream_setup: inst_valid=%b in flight=%0d, required 1 and >0",
                     inst_valid, mq.size());
        end
        step(1'b1, 1'b0, '0, 1'b1);
        check_reset_outputs("midstream_reset_values");
        step(1'b1, 1'b0, '0, 1'b1);
        check_first_request("midstream_first_request");
        lat_min = 1; lat_max = 4; rdy_rand = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] tgt;
        lat_min = 1; lat_max = 4; rdy_rand = 1'b1;
        xfers = 0;
        for (int i = 0; i < 400; i++) begin
            tgt = {$urandom, $urandom};
            step(1'b0, ($urandom_range(0, 19) == 0), tgt, ($urandom_range(0, 2) != 0));
        end
        tests++;
        if (xfers < 50) begin
            fails++;
            $display("FAIL random_progress: got %0d transfers, required >= 50", xfers);
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        exp_req        = RESET_PC;
        exp_pc         = RESET_PC;
        last_fire_addr = '0;
        last_xfer_pc   = '0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
